// File: rtl/led_breathe.sv
// ----------------------------------------------------------------------------
// led_breathe
//
// "Breathing" LED driver: an 8-bit PWM whose duty ramps up to full scale,
// holds there, ramps back down to zero, holds, and repeats.
//
// Ports
//   clk     in   1  system clock (12 MHz); all state changes on the rising edge
//   rst_n   in   1  asynchronous active-low reset, released synchronously
//   enable  in   1  synchronous run/stop; low puts everything back to reset
//   led     out  1  registered PWM drive, active-high
//   duty    out  8  duty value the PWM comparator is currently using
//   phase   out  2  ramp state: 0 RISE, 1 HOLD_HI, 2 FALL, 3 HOLD_LO
//
// Parameters
//   STEP_DIV    ramp step strobe every STEP_DIV+1 clocks (0 .. 2^24-1)
//   HOLD_STEPS  step strobes spent at the peak and at the trough (1 .. 65535)
//
// State     | meaning
// ----------+---------------------------------------------------------------
// RISE      | level climbs by one per strobe until it reaches 255
// HOLD_HI   | level parked at 255 for HOLD_STEPS strobes
// FALL      | level drops by one per strobe until it reaches 0
// HOLD_LO   | level parked at 0 for HOLD_STEPS strobes, then back to RISE
// ----------------------------------------------------------------------------
module led_breathe #(
  parameter int unsigned STEP_DIV   = 11718,
  parameter int unsigned HOLD_STEPS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       led,
  output logic [7:0] duty,
  output logic [1:0] phase
);

  localparam logic [23:0] STEP_TC = 24'(STEP_DIV);
  localparam logic [15:0] HOLD_TC = 16'(HOLD_STEPS - 1);

  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // Reset synchroniser: assertion is immediate, release takes two edges.
  // The datapath keeps itself in reset until rst_sync_q[1] is seen high, so
  // the first count happens on the third edge after rst_n rises.
  // --------------------------------------------------------------------------
  logic [1:0] rst_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  logic run;
  assign run = rst_sync_q[1] & enable;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  state_e      state_q,    state_d;
  logic [7:0]  pwm_cnt_q,  pwm_cnt_d;
  logic [23:0] step_cnt_q, step_cnt_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]  level_q,    level_d;
  logic [7:0]  duty_q,     duty_d;
  logic        led_q,      led_d;

  logic       strobe;
  logic [7:0] level_up;
  logic [7:0] level_dn;

  assign strobe = (step_cnt_q == STEP_TC);

  // Saturating neighbours of the current level; level must never wrap.
  assign level_up = (level_q == 8'hFF) ? 8'hFF : level_q + 8'd1;
  assign level_dn = (level_q == 8'h00) ? 8'h00 : level_q - 8'd1;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    hold_cnt_d = hold_cnt_q;
    pwm_cnt_d  = pwm_cnt_q + 8'd1;
    step_cnt_d = strobe ? 24'd0 : step_cnt_q + 24'd1;
    led_d      = (pwm_cnt_q < duty_q);
    // Duty only reloads on the last slot of a PWM period, and it takes the
    // level as it stands before any strobe on this same edge. A level change
    // made by a coincident strobe is therefore picked up one period later.
    duty_d     = (pwm_cnt_q == 8'hFF) ? level_q : duty_q;

    if (strobe) begin
      unique case (state_q)
        RISE: begin
          level_d = level_up;
          if (level_up == 8'hFF) begin
            state_d    = HOLD_HI;
            hold_cnt_d = 16'd0;
          end
        end
        HOLD_HI: begin
          level_d = 8'hFF;
          if (hold_cnt_q == HOLD_TC) begin
            state_d    = FALL;
            hold_cnt_d = 16'd0;
          end else begin
            hold_cnt_d = hold_cnt_q + 16'd1;
          end
        end
        FALL: begin
          level_d = level_dn;
          if (level_dn == 8'h00) begin
            state_d    = HOLD_LO;
            hold_cnt_d = 16'd0;
          end
        end
        HOLD_LO: begin
          level_d = 8'h00;
          if (hold_cnt_q == HOLD_TC) begin
            state_d    = RISE;
            hold_cnt_d = 16'd0;
          end else begin
            hold_cnt_d = hold_cnt_q + 16'd1;
          end
        end
        default: begin
          state_d    = RISE;
          level_d    = 8'h00;
          hold_cnt_d = 16'd0;
        end
      endcase
    end

    // Stopped, or still coming out of reset: return everything to the
    // reset values. Progress is discarded, there is no resume.
    if (!run) begin
      state_d    = RISE;
      level_d    = 8'h00;
      hold_cnt_d = 16'd0;
      pwm_cnt_d  = 8'd0;
      step_cnt_d = 24'd0;
      led_d      = 1'b0;
      duty_d     = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RISE;
      level_q    <= 8'h00;
      hold_cnt_q <= 16'd0;
      pwm_cnt_q  <= 8'd0;
      step_cnt_q <= 24'd0;
      led_q      <= 1'b0;
      duty_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      hold_cnt_q <= hold_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      led_q      <= led_d;
      duty_q     <= duty_d;
    end
  end

  assign led   = led_q;
  assign duty  = duty_q;
  assign phase = state_q;

endmodule

// File: tb/tb_led_breathe.sv
// ----------------------------------------------------------------------------
// tb_led_breathe
//
// The reference model works from the count n of running clock edges since the
// last (re)start. The ramp is a closed-form triangle wave over the number of
// step strobes k = n / (STEP_DIV+1); duty is the level sampled at the last
// PWM-period boundary; led compares the PWM slot against that duty.
// A driver pushes the expected outputs per cycle into a queue, a separate
// monitor pops and compares them against the DUT.
// ----------------------------------------------------------------------------
module tb_led_breathe;

  localparam int S = 3;
  localparam int H = 140;              // long enough for whole PWM periods at 255
  localparam int P = 510 + 2 * H;      // strobes per full breathing cycle

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       enable = 1'b0;
  logic       led;
  logic [7:0] duty;
  logic [1:0] phase;

  led_breathe #(.STEP_DIV(S), .HOLD_STEPS(H)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .led    (led),
    .duty   (duty),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       led;
    logic [7:0] duty;
    logic [1:0] phase;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rel    = 0;   // edges seen since rst_n went high
  int   n      = 0;   // running edges since last restart

  // Level after k strobes: 0..254 rising, hold at 255, fall 255..1, hold at 0.
  function automatic int lvl_of(input int k);
    int m;
    m = k % P;
    if (m < 255)           return m;
    else if (m < 255 + H)  return 255;
    else if (m < 510 + H)  return 255 - (m - 255 - H);
    else                   return 0;
  endfunction

  function automatic int ph_of(input int k);
    int m;
    m = k % P;
    if (m < 255)           return 0;
    else if (m < 255 + H)  return 1;
    else if (m < 510 + H)  return 2;
    else                   return 3;
  endfunction

  // Duty after nn running edges: level as it was just before the most recent
  // edge that closed a 256-slot PWM period.
  function automatic int duty_of(input int nn);
    int nd;
    if (nn < 256) return 0;
    nd = (nn / 256) * 256;
    return lvl_of((nd - 1) / (S + 1));
  endfunction

  function automatic int led_of(input int nn);
    if (nn == 0) return 0;
    return (((nn - 1) % 256) < duty_of(nn - 1)) ? 1 : 0;
  endfunction

  task automatic step(input logic en_v, input logic rst_v);
    exp_t e;
    @(posedge clk);
    if (!rst_n) begin
      rel = 0;
      n   = 0;
    end else begin
      if (rel < 3) rel++;
      if (rel >= 3 && enable) n++;
      else n = 0;
    end
    #1;
    enable = en_v;
    rst_n  = rst_v;
    if (!rst_v) begin
      rel = 0;
      n   = 0;
    end
    #1;
    e.led   = 1'(led_of(n));
    e.duty  = 8'(duty_of(n));
    e.phase = 2'(ph_of(n / (S + 1)));
    exp_q.push_back(e);
  endtask

  task automatic timeout(input string what);
    checks++;
    errors++;
    $display("FAIL timeout %s: condition not reached, required within bound", what);
  endtask

  // Monitor: compares each cycle, mid-way between clock edges.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL no_expect at %0t: actual led=%0b duty=%0d phase=%0d, required an expected entry",
                 $time, led, duty, phase);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (led !== e.led) begin
          errors++;
          if (errors < 30) $display("FAIL led at %0t: actual %0b required %0b", $time, led, e.led);
        end
        checks++;
        if (duty !== e.duty) begin
          errors++;
          if (errors < 30) $display("FAIL duty at %0t: actual %0d required %0d", $time, duty, e.duty);
        end
        checks++;
        if (phase !== e.phase) begin
          errors++;
          if (errors < 30) $display("FAIL phase at %0t: actual %0d required %0d", $time, phase, e.phase);
        end
      end
    end
  end

  initial begin
    int extra;
    // Held in reset, then released with enable high.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b1);

    // Ramp up into the peak hold, then pulse reset asynchronously mid-hold.
    for (int i = 0; i < 3000 && ph_of(n / (S + 1)) != 1; i++) step(1'b1, 1'b1);
    if (ph_of(n / (S + 1)) != 1) timeout("reach_hold_hi");
    extra = int'($urandom_range(0, 4 * H - 40));
    for (int i = 0; i < extra; i++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    // Ramp down to level 100 in FALL, stop, and restart.
    for (int i = 0; i < 8000 && !(ph_of(n / (S + 1)) == 2 && lvl_of(n / (S + 1)) == 100); i++)
      step(1'b1, 1'b1);
    if (!(ph_of(n / (S + 1)) == 2 && lvl_of(n / (S + 1)) == 100)) timeout("reach_fall_100");
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    // One uninterrupted full breathing cycle plus margin.
    for (int i = 0; i < 4 * P + 600; i++) step(1'b1, 1'b1);

    // Random stops and reset pulses.
    for (int i = 0; i < 6000; i++) begin
      step(($urandom_range(0, 499) != 0), ($urandom_range(0, 799) != 0));
    end

    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
